// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg: shared types and default sizes for the memory scheduler
package mem_sched_pkg;
  localparam int DEF_PA_WIDTH = 32;
  localparam int DEF_LINE_BYTES = 16;
  localparam int DEF_ID_WIDTH = 4;
  typedef enum logic {OWN_INSTR, OWN_DATA} owner_e;
  typedef struct packed {
    logic valid;
    owner_e owner;
    logic killed;
  } trk_entry_t;
  typedef struct packed {
    logic [DEF_PA_WIDTH-1:0] addr;
    logic [DEF_LINE_BYTES*8-1:0] data;
    logic write;
    logic [DEF_ID_WIDTH-1:0] id;
  } mem_req_t;
endpackage

// File: rtl/mem_sched_if.sv
// mem_sched_if: requester, memory and status signals of the memory scheduler
interface mem_sched_if
  import mem_sched_pkg::*;
#(
  parameter int PA_WIDTH = DEF_PA_WIDTH,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int ID_WIDTH = DEF_ID_WIDTH
);
  logic i_instr_enable;
  logic [PA_WIDTH-1:0] i_instr_addr;
  logic i_instr_kill;
  logic i_data_enable;
  logic [PA_WIDTH-1:0] i_data_addr;
  logic [LINE_BYTES*8-1:0] i_data;
  logic i_data_write;
  logic i_mem_full;
  logic i_resp_enable;
  logic [ID_WIDTH-1:0] i_resp_id;
  logic i_instr_ack;
  logic i_data_ack;
  logic o_mem_enable;
  logic o_mem_write;
  logic [PA_WIDTH-1:0] o_mem_addr;
  logic [LINE_BYTES*8-1:0] o_mem_data;
  logic [ID_WIDTH-1:0] o_mem_id;
  logic o_mem_ack;
  logic o_instr_grant;
  logic o_data_grant;
  logic [ID_WIDTH-1:0] o_id_of_instr;
  logic [ID_WIDTH-1:0] o_id_of_data;
  logic [ID_WIDTH:0] o_outstanding;
  logic o_full;
  modport master (
    output i_instr_enable, i_instr_addr, i_instr_kill, i_data_enable, i_data_addr, i_data,
           i_data_write, i_mem_full, i_resp_enable, i_resp_id, i_instr_ack, i_data_ack,
    input  o_mem_enable, o_mem_write, o_mem_addr, o_mem_data, o_mem_id, o_mem_ack,
           o_instr_grant, o_data_grant, o_id_of_instr, o_id_of_data, o_outstanding, o_full
  );
  modport slave (
    input  i_instr_enable, i_instr_addr, i_instr_kill, i_data_enable, i_data_addr, i_data,
           i_data_write, i_mem_full, i_resp_enable, i_resp_id, i_instr_ack, i_data_ack,
    output o_mem_enable, o_mem_write, o_mem_addr, o_mem_data, o_mem_id, o_mem_ack,
           o_instr_grant, o_data_grant, o_id_of_instr, o_id_of_data, o_outstanding, o_full
  );
endinterface

// File: rtl/mem_scheduler_id_alloc.sv
// id_alloc: response ID pool as a used bitmap with lowest-free pick, popcount and full flag
module id_alloc #(
  parameter int ID_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic alloc,
  input  logic free,
  input  logic [ID_WIDTH-1:0] free_id,
  output logic [ID_WIDTH-1:0] alloc_id,
  output logic full,
  output logic [ID_WIDTH:0] count,
  output logic [2**ID_WIDTH-1:0] used
);
  localparam int N = 2**ID_WIDTH;
  // lowest free index and number of used IDs, both from the current bitmap
  always_comb begin
    alloc_id = '0;
    count = '0;
    for (int i = N - 1; i >= 0; i--) alloc_id = !used[i] ? ID_WIDTH'(i) : alloc_id;
    for (int i = 0; i < N; i++) count = count + (ID_WIDTH+1)'(used[i]);
  end
  assign full = &used;
  // a freed ID only becomes pickable the cycle after it is released
  always_ff @(posedge clk)
    if (rst) used <= '0;
    else used <= (used & ~(N'(free) << free_id)) | (N'(alloc) << alloc_id);
endmodule

// File: rtl/mem_scheduler.sv
// mem_scheduler: starvation-free ime/dme arbiter with ID tracking; MEM_SCHED_PERF_EN adds perf counters
module mem_scheduler
  import mem_sched_pkg::*;
#(
  parameter int PA_WIDTH = DEF_PA_WIDTH,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int ID_WIDTH = DEF_ID_WIDTH,
  parameter int STARVE_LIMIT = 8
) (
  input logic clk,
  input logic rst,
  mem_sched_if.slave bus
`ifdef MEM_SCHED_PERF_EN
  ,
  output logic [31:0] o_perf_instr_grants,
  output logic [31:0] o_perf_data_grants,
  output logic [31:0] o_perf_full_cycles
`endif
);
  localparam int N = 2**ID_WIDTH;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [N-1:0] used;
  logic [ID_WIDTH-1:0] alloc_id;
  logic full;
  logic [ID_WIDTH:0] count;
  owner_e owner_q [N];
  logic [N-1:0] killed_q;
  logic [SW-1:0] starve_q;
  logic force_i, instr_ok, data_ok, grant_i, grant_d, grant_rd, own_ack, retire;
  trk_entry_t rsp_trk;
  assign rsp_trk = '{valid: used[bus.i_resp_id], owner: owner_q[bus.i_resp_id], killed: killed_q[bus.i_resp_id]};
  // arbitration: data by default, instr once it has lost STARVE_LIMIT cycles in a row
  always_comb begin
    force_i = starve_q == SW'(STARVE_LIMIT);
    instr_ok = bus.i_instr_enable && !full;
    data_ok = bus.i_data_enable && (bus.i_data_write || !full);
    grant_i = !rst && !bus.i_mem_full && instr_ok && (force_i || !data_ok);
    grant_d = !rst && !bus.i_mem_full && data_ok && !grant_i;
    grant_rd = grant_i || (grant_d && !bus.i_data_write);
    own_ack = rsp_trk.owner == OWN_INSTR ? bus.i_instr_ack : bus.i_data_ack;
    retire = !rst && bus.i_resp_enable && rsp_trk.valid && (rsp_trk.killed || own_ack);
  end
  assign bus.o_instr_grant = grant_i;
  assign bus.o_data_grant = grant_d;
  assign bus.o_mem_ack = retire;
  assign bus.o_full = full;
  assign bus.o_outstanding = count;
  id_alloc #(.ID_WIDTH(ID_WIDTH)) u_id_alloc (
    .clk(clk),
    .rst(rst),
    .alloc(grant_rd),
    .free(retire),
    .free_id(bus.i_resp_id),
    .alloc_id(alloc_id),
    .full(full),
    .count(count),
    .used(used)
  );
  // registered issue, starvation counter and per-ID owner/killed tracking
  always_ff @(posedge clk)
    if (rst) begin
      starve_q <= '0;
      bus.o_mem_enable <= 1'b0;
      bus.o_mem_write <= 1'b0;
      bus.o_mem_addr <= '0;
      bus.o_mem_data <= '0;
      bus.o_mem_id <= '0;
      bus.o_id_of_instr <= '0;
      bus.o_id_of_data <= '0;
      killed_q <= '0;
    end else begin
      starve_q <= (!bus.i_instr_enable || grant_i) ? '0 : force_i ? starve_q : starve_q + SW'(1);
      bus.o_mem_enable <= grant_i || grant_d;
      bus.o_mem_write <= grant_d && bus.i_data_write;
      bus.o_mem_addr <= grant_i ? bus.i_instr_addr : grant_d ? bus.i_data_addr : '0;
      bus.o_mem_data <= (grant_d && bus.i_data_write) ? bus.i_data : '0;
      bus.o_mem_id <= grant_rd ? alloc_id : '0;
      if (grant_i) bus.o_id_of_instr <= alloc_id;
      if (grant_d && !bus.i_data_write) bus.o_id_of_data <= alloc_id;
      for (int j = 0; j < N; j++)
        if (bus.i_instr_kill && used[j] && owner_q[j] == OWN_INSTR) killed_q[j] <= 1'b1;
      if (grant_rd) begin
        owner_q[alloc_id] <= grant_i ? OWN_INSTR : OWN_DATA;
        killed_q[alloc_id] <= grant_i && bus.i_instr_kill;
      end
    end
`ifdef MEM_SCHED_PERF_EN
  // grant counts and cycles where a pending request is blocked by a full pool or memory
  always_ff @(posedge clk)
    if (rst) begin
      o_perf_instr_grants <= '0;
      o_perf_data_grants <= '0;
      o_perf_full_cycles <= '0;
    end else begin
      o_perf_instr_grants <= o_perf_instr_grants + 32'(grant_i);
      o_perf_data_grants <= o_perf_data_grants + 32'(grant_d);
      o_perf_full_cycles <= o_perf_full_cycles + 32'((bus.i_instr_enable || bus.i_data_enable) && !grant_i && !grant_d && (full || bus.i_mem_full));
    end
`endif
endmodule

// File: tb/tb_mem_scheduler.sv
// tb_mem_scheduler: scoreboard bench for mem_scheduler
module tb_mem_scheduler;
  import mem_sched_pkg::*;
  typedef struct {
    mem_req_t req;
    int due;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int passes = 0;
  bit tb_used [16];
  exp_t sb [$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mem_sched_if bus ();
`ifdef MEM_SCHED_PERF_EN
  logic [31:0] perf_i, perf_d, perf_f;
  mem_scheduler dut (.clk(clk), .rst(rst), .bus(bus), .o_perf_instr_grants(perf_i), .o_perf_data_grants(perf_d), .o_perf_full_cycles(perf_f));
`else
  mem_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  // issue monitor: every registered issue must match the oldest expectation due this cycle
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        checks++;
        $display("FAIL issue_missing due=%0d now=%0d addr=%h", e.due, cyc, e.req.addr);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        checks++;
        if (bus.o_mem_enable !== 1'b1 || bus.o_mem_write !== e.req.write || bus.o_mem_addr !== e.req.addr ||
            bus.o_mem_id !== e.req.id || bus.o_mem_data !== e.req.data)
          $display("FAIL issue got en=%0b wr=%0b addr=%h id=%0d data=%h want en=1 wr=%0b addr=%h id=%0d data=%h",
                   bus.o_mem_enable, bus.o_mem_write, bus.o_mem_addr, bus.o_mem_id, bus.o_mem_data,
                   e.req.write, e.req.addr, e.req.id, e.req.data);
        else passes++;
      end else begin
        checks++;
        if (bus.o_mem_enable !== 1'b0) $display("FAIL issue_unexpected got en=%0b want 0 at cyc %0d", bus.o_mem_enable, cyc);
        else passes++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.i_instr_enable = 0; bus.i_instr_addr = '0; bus.i_instr_kill = 0;
    bus.i_data_enable = 0; bus.i_data_addr = '0; bus.i_data = '0; bus.i_data_write = 0;
    bus.i_mem_full = 0; bus.i_resp_enable = 0; bus.i_resp_id = '0;
    bus.i_instr_ack = 0; bus.i_data_ack = 0;
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 16; i++) if (!tb_used[i]) return i;
    return 0;
  endfunction

  task automatic push_read(input logic [31:0] a);
    exp_t e;
    int id;
    id = lowest_free();
    e.req.addr = a; e.req.data = '0; e.req.write = 1'b0; e.req.id = 4'(id);
    e.due = cyc + 1;
    sb.push_back(e);
    tb_used[id] = 1;
  endtask

  task automatic push_write(input logic [31:0] a, input logic [127:0] d);
    exp_t e;
    e.req.addr = a; e.req.data = d; e.req.write = 1'b1; e.req.id = '0;
    e.due = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic do_reset;
    rst = 1; idle;
    tick;
    tick;
    rst = 0;
    for (int i = 0; i < 16; i++) tb_used[i] = 0;
  endtask

  task automatic test_reset;
    idle;
    bus.i_instr_enable = 1; bus.i_instr_addr = 32'h40;
    tick;
    tick;
    checks++; if (bus.o_mem_enable !== 1'b0) $display("FAIL reset_mem_enable got %0b want 0", bus.o_mem_enable); else passes++;
    checks++; if (bus.o_outstanding !== 5'd0) $display("FAIL reset_outstanding got %0d want 0", bus.o_outstanding); else passes++;
    checks++; if (bus.o_full !== 1'b0) $display("FAIL reset_full got %0b want 0", bus.o_full); else passes++;
    checks++; if (bus.o_instr_grant !== 1'b0) $display("FAIL reset_instr_grant got %0b want 0", bus.o_instr_grant); else passes++;
    checks++; if (bus.o_mem_ack !== 1'b0) $display("FAIL reset_mem_ack got %0b want 0", bus.o_mem_ack); else passes++;
    checks++; if (bus.o_id_of_instr !== 4'd0 || bus.o_id_of_data !== 4'd0) $display("FAIL reset_ids got %0d/%0d want 0/0", bus.o_id_of_instr, bus.o_id_of_data); else passes++;
    idle;
    rst = 0;
  endtask

  task automatic test_single_read;
    tick;
    bus.i_instr_enable = 1; bus.i_instr_addr = 32'h100;
    #1;
    checks++; if (bus.o_instr_grant !== 1'b1) $display("FAIL single_grant got %0b want 1", bus.o_instr_grant); else passes++;
    push_read(32'h100);
    tick;
    bus.i_instr_enable = 0;
    #1;
    checks++; if (bus.o_outstanding !== 5'd1) $display("FAIL single_outstanding got %0d want 1", bus.o_outstanding); else passes++;
    checks++; if (bus.o_id_of_instr !== 4'd0) $display("FAIL single_id_of_instr got %0d want 0", bus.o_id_of_instr); else passes++;
    bus.i_resp_enable = 1; bus.i_resp_id = 4'd0; bus.i_instr_ack = 1;
    #1;
    checks++; if (bus.o_mem_ack !== 1'b1) $display("FAIL single_ack got %0b want 1", bus.o_mem_ack); else passes++;
    tick;
    idle;
    tb_used[0] = 0;
    #1;
    checks++; if (bus.o_outstanding !== 5'd0) $display("FAIL single_retired got %0d want 0", bus.o_outstanding); else passes++;
  endtask

  task automatic test_starve;
    logic exp_i;
    do_reset;
    tick;
    bus.i_instr_enable = 1; bus.i_instr_addr = 32'h200;
    bus.i_data_enable = 1; bus.i_data_addr = 32'h300;
    for (int k = 0; k < 10; k++) begin
      #1;
      exp_i = (k == 8);
      checks++;
      if (bus.o_instr_grant !== exp_i || bus.o_data_grant !== !exp_i)
        $display("FAIL starve_round%0d got i=%0b d=%0b want i=%0b d=%0b", k, bus.o_instr_grant, bus.o_data_grant, exp_i, !exp_i);
      else passes++;
      push_read(exp_i ? 32'h200 : 32'h300);
      tick;
    end
    idle;
    #1;
    checks++; if (bus.o_outstanding !== 5'd10) $display("FAIL starve_outstanding got %0d want 10", bus.o_outstanding); else passes++;
    checks++; if (bus.o_id_of_instr !== 4'd8) $display("FAIL starve_id_of_instr got %0d want 8", bus.o_id_of_instr); else passes++;
    tick;
  endtask

  task automatic test_kill;
    do_reset;
    tick;
    bus.i_data_enable = 1;
    for (int k = 0; k < 3; k++) begin
      bus.i_data_addr = 32'h400 + 32'(k * 16);
      #1;
      checks++; if (bus.o_data_grant !== 1'b1) $display("FAIL kill_data_grant%0d got %0b want 1", k, bus.o_data_grant); else passes++;
      push_read(bus.i_data_addr);
      tick;
    end
    idle;
    bus.i_instr_enable = 1; bus.i_instr_addr = 32'h500;
    #1;
    checks++; if (bus.o_instr_grant !== 1'b1) $display("FAIL kill_instr_grant got %0b want 1", bus.o_instr_grant); else passes++;
    push_read(32'h500);
    tick;
    idle;
    bus.i_instr_kill = 1;
    #1;
    checks++; if (bus.o_id_of_instr !== 4'd3) $display("FAIL kill_id3 got %0d want 3", bus.o_id_of_instr); else passes++;
    tick;
    idle;
    bus.i_resp_enable = 1; bus.i_resp_id = 4'd3;
    #1;
    checks++; if (bus.o_mem_ack !== 1'b1) $display("FAIL kill_self_retire got %0b want 1", bus.o_mem_ack); else passes++;
    checks++; if (bus.o_outstanding !== 5'd4) $display("FAIL kill_outstanding_before got %0d want 4", bus.o_outstanding); else passes++;
    tick;
    tb_used[3] = 0;
    bus.i_resp_id = 4'd0;
    #1;
    checks++; if (bus.o_mem_ack !== 1'b0) $display("FAIL kill_data_unaffected got %0b want 0", bus.o_mem_ack); else passes++;
    checks++; if (bus.o_outstanding !== 5'd3) $display("FAIL kill_id3_freed got %0d want 3", bus.o_outstanding); else passes++;
    tick;
    idle;
    bus.i_instr_enable = 1; bus.i_instr_addr = 32'h600; bus.i_instr_kill = 1;
    #1;
    checks++; if (bus.o_instr_grant !== 1'b1) $display("FAIL kill_same_cycle_grant got %0b want 1", bus.o_instr_grant); else passes++;
    push_read(32'h600);
    tick;
    idle;
    tick;
    bus.i_resp_enable = 1; bus.i_resp_id = 4'd3;
    #1;
    checks++; if (bus.o_mem_ack !== 1'b1) $display("FAIL kill_same_cycle_retire got %0b want 1", bus.o_mem_ack); else passes++;
    tick;
    idle;
    tb_used[3] = 0;
  endtask

  task automatic test_full;
    logic [127:0] wd;
    wd = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    do_reset;
    tick;
    bus.i_data_enable = 1;
    for (int k = 0; k < 16; k++) begin
      bus.i_data_addr = 32'h1000 + 32'(k * 16);
      #1;
      checks++; if (bus.o_data_grant !== 1'b1) $display("FAIL full_fill%0d got %0b want 1", k, bus.o_data_grant); else passes++;
      push_read(bus.i_data_addr);
      tick;
    end
    bus.i_data_addr = 32'h1100; bus.i_instr_enable = 1; bus.i_instr_addr = 32'h700;
    #1;
    checks++; if (bus.o_full !== 1'b1) $display("FAIL full_flag got %0b want 1", bus.o_full); else passes++;
    checks++; if (bus.o_outstanding !== 5'd16) $display("FAIL full_outstanding got %0d want 16", bus.o_outstanding); else passes++;
    checks++; if (bus.o_data_grant !== 1'b0 || bus.o_instr_grant !== 1'b0) $display("FAIL full_read_blocked got d=%0b i=%0b want 0/0", bus.o_data_grant, bus.o_instr_grant); else passes++;
    bus.i_data_write = 1; bus.i_data_addr = 32'h2000; bus.i_data = wd;
    #1;
    checks++; if (bus.o_data_grant !== 1'b1 || bus.o_instr_grant !== 1'b0) $display("FAIL full_write_grant got d=%0b i=%0b want 1/0", bus.o_data_grant, bus.o_instr_grant); else passes++;
    push_write(32'h2000, wd);
    tick;
    idle;
    tick;
  endtask

  task automatic test_mem_full;
    do_reset;
    tick;
    bus.i_instr_enable = 1; bus.i_instr_addr = 32'h800;
    bus.i_data_enable = 1; bus.i_data_addr = 32'h900;
    bus.i_mem_full = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.o_instr_grant !== 1'b0 || bus.o_data_grant !== 1'b0) $display("FAIL memfull_grant%0d got i=%0b d=%0b want 0/0", k, bus.o_instr_grant, bus.o_data_grant); else passes++;
      checks++; if (bus.o_mem_enable !== 1'b0) $display("FAIL memfull_enable%0d got %0b want 0", k, bus.o_mem_enable); else passes++;
      tick;
    end
    bus.i_mem_full = 0;
    #1;
    checks++; if (bus.o_data_grant !== 1'b1 || bus.o_instr_grant !== 1'b0) $display("FAIL memfull_release got d=%0b i=%0b want 1/0", bus.o_data_grant, bus.o_instr_grant); else passes++;
    push_read(32'h900);
    tick;
    idle;
    tick;
  endtask

  task automatic test_rst_mid;
    do_reset;
    tick;
    bus.i_data_enable = 1;
    for (int k = 0; k < 5; k++) begin
      bus.i_data_addr = 32'h3000 + 32'(k * 16);
      #1;
      push_read(bus.i_data_addr);
      tick;
    end
    idle;
    tick;
    checks++; if (bus.o_outstanding !== 5'd5) $display("FAIL rstmid_before got %0d want 5", bus.o_outstanding); else passes++;
    rst = 1;
    tick;
    #1;
    checks++; if (bus.o_outstanding !== 5'd0) $display("FAIL rstmid_cleared got %0d want 0", bus.o_outstanding); else passes++;
    rst = 0;
    for (int i = 0; i < 16; i++) tb_used[i] = 0;
    tick;
    bus.i_resp_enable = 1; bus.i_resp_id = 4'd2; bus.i_data_ack = 1;
    #1;
    checks++; if (bus.o_mem_ack !== 1'b0) $display("FAIL rstmid_stale_resp got %0b want 0", bus.o_mem_ack); else passes++;
    tick;
    idle;
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_starve;
    test_kill;
    test_full;
    test_mem_full;
    test_rst_mid;
    tick;
    tick;
    checks++; if (sb.size() != 0) $display("FAIL scoreboard_drained got %0d want 0", sb.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mem_scheduler.md
Name: mem_scheduler

Overview:
- Shares the single pipelined memory port between the instruction-side (ime) and data-side (dme) miss engines.
- Arbitrates requests, allocates response IDs from a free pool and tracks outstanding reads.
- Retires IDs on requester ack, and self-retires responses whose instruction fetch was killed by a branch.
- Sits between ime/dme and memory; replaces the stateless arbiter with a stateful, starvation-free scheduler.

Parameters:
- PA_WIDTH, 32, physical address width
- LINE_BYTES, 16, cache line size; data bus is LINE_BYTES*8 bits
- ID_WIDTH, 4, response ID width; pool holds 2**ID_WIDTH IDs
- STARVE_LIMIT, 8, consecutive cycles an instr request may lose before it is forced to win

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_instr_enable  in  1  instr-side read request, held until o_instr_grant
- i_instr_addr  in  PA_WIDTH  instr line address
- i_instr_kill  in  1  branch redirect; outstanding instr reads become killed
- i_data_enable  in  1  data-side request, held until o_data_grant
- i_data_addr  in  PA_WIDTH  data line address
- i_data  in  LINE_BYTES*8  store line
- i_data_write  in  1  1 = write-back, 0 = read
- i_mem_full  in  1  memory cannot accept this cycle
- i_resp_enable  in  1  memory response valid
- i_resp_id  in  ID_WIDTH  response ID
- i_instr_ack  in  1  ime consumed response i_resp_id
- i_data_ack  in  1  dme consumed response i_resp_id
- o_mem_enable  out  1  issue strobe to memory
- o_mem_write  out  1  issued op is a write
- o_mem_addr  out  PA_WIDTH  issued address
- o_mem_data  out  LINE_BYTES*8  issued write data
- o_mem_id  out  ID_WIDTH  issued ID
- o_mem_ack  out  1  ack to memory (requester ack or self-retire)
- o_instr_grant  out  1  instr request accepted this cycle
- o_data_grant  out  1  data request accepted this cycle
- o_id_of_instr  out  ID_WIDTH  ID assigned to the last instr grant
- o_id_of_data  out  ID_WIDTH  ID assigned to the last data grant
- o_outstanding  out  ID_WIDTH+1  number of valid tracker entries
- o_full  out  1  no free ID

Behaviour:
- Reset: all outputs 0; all tracker entries invalid; starve counter 0; o_outstanding 0.
- Tracker entry per ID: valid, owner (INSTR/DATA), killed.
- Issue condition: !i_mem_full, at least one request, and a free ID exists (a write needs no ID).
  - Winner: data wins, unless starve_cnt == STARVE_LIMIT, in which case instr wins.
- starve_cnt:
  - increments when instr is pending and loses;
  - clears on instr grant or when instr is not pending;
  - saturates at STARVE_LIMIT.
- Grant is combinational in cycle T (o_*_grant = 1). The o_mem_* outputs are registered and valid in T+1 for exactly one cycle. Grant-to-issue latency is 1.
- Read grant: allocate the lowest-index free ID, set valid/owner, and clear killed. The ID appears on o_mem_id and on o_id_of_<side> at T+1.
- Write grant: no tracker entry. o_mem_id = 0 and o_mem_write = 1.
- Kill: i_instr_kill sets killed on every valid INSTR entry. If i_instr_kill is asserted in the same cycle as an instr grant, that new entry is also killed.
- Retire on response (i_resp_enable with entry valid), one of:
  - killed: o_mem_ack = 1 in the same cycle and the entry is freed; the requester ack is ignored;
  - else the owner's ack (i_instr_ack for INSTR, i_data_ack for DATA) frees the entry and drives o_mem_ack = 1;
  - else the entry stays valid and the response is retried by memory.
- A response for an invalid ID is ignored (no ack).
- Retire and allocate in the same cycle: the freed ID is not reusable until T+1.
- o_full = 1 when all IDs are valid: reads are not granted, writes still are.
- i_mem_full = 1: no grants; the registered issue outputs drop to 0 next cycle.
- o_outstanding always equals the popcount of valid entries.
- rst mid-operation: all entries are discarded immediately; in-flight memory responses after reset are treated as invalid IDs.

Optional Feature:
MEM_SCHED_PERF_EN
- Defined: adds 32-bit wrapping outputs o_perf_instr_grants, o_perf_data_grants, o_perf_full_cycles (counts cycles with a request pending and blocked by o_full or i_mem_full). All cleared on rst.
- Undefined: these ports and counters do not exist.

Decomposition:
- Shared package mem_sched_pkg:
  - owner_e enum {OWN_INSTR, OWN_DATA};
  - trk_entry_t struct {valid, owner, killed};
  - mem_req_t struct {addr, data, write, id}.
- One natural sub-module: id_alloc, a free bitmap with a lowest-free priority encoder, popcount, alloc/free ports and a full flag.

Test Plan:
- Only instr read, addr 0x100, ID pool empty -> grant T, o_mem_enable/addr 0x100/id 0 at T+1; response id0 + i_instr_ack -> o_mem_ack = 1, o_outstanding 1 -> 0.
- instr and data reads held continuously, STARVE_LIMIT = 8 -> data wins 8 cycles, instr wins the 9th, counter clears.
- Issue instr read id3, assert i_instr_kill, response id3 without i_instr_ack -> o_mem_ack = 1 same cycle, id3 free next cycle.
- Issue 16 data reads with no acks -> o_full = 1, 17th read not granted, data write still granted with o_mem_write = 1 and id 0.
- i_mem_full held 3 cycles with both requests pending -> no grants, o_mem_enable = 0; on release data granted first.
- Assert rst with 5 entries outstanding -> o_outstanding = 0 next cycle; subsequent response id2 -> no o_mem_ack.
